// File: rtl/mgpu_mtrx_pkg.sv
// Shared types and defaults for the matrix stream sequencer.
// Optional feature macro used by the top: MTRX_SEQ_SKIP_EN.
package mgpu_mtrx_pkg;

    localparam int unsigned DEF_ELEM_W = 16;
    localparam int unsigned DEF_DIM    = 4;
    localparam int unsigned MTRX_W     = DEF_DIM * DEF_DIM * DEF_ELEM_W;
    localparam int unsigned MAX_MTRX   = 14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

    // Matrix k out of a flattened bank laid out at [k*MTRX_W +: MTRX_W].
    function automatic logic [MTRX_W-1:0] mtrx_slice(
        input logic [MAX_MTRX*MTRX_W-1:0] flat,
        input int unsigned                k
    );
        return flat[k*MTRX_W +: MTRX_W];
    endfunction

endpackage

// File: rtl/mtrx_snap_buf.sv
// Snapshot register bank: loads every matrix on one strobe and serves one
// matrix per cycle through an index read port.
module mtrx_snap_buf #(
    parameter int unsigned NUM_MTRX = 6,
    parameter int unsigned MTRX_W   = 256,
    parameter int unsigned IDX_W    = 3
) (
    input  logic                       clk,
    input  logic                       load,
    input  logic [NUM_MTRX*MTRX_W-1:0] data_in,
    input  logic [IDX_W-1:0]           rd_idx,
    output logic [MTRX_W-1:0]          rd_data
);

    logic [MTRX_W-1:0] bank [NUM_MTRX];

    always_ff @(posedge clk) begin
        if (load) begin
            for (int unsigned k = 0; k < NUM_MTRX; k++) begin
                bank[k] <= data_in[k*MTRX_W +: MTRX_W];
            end
        end
    end

    assign rd_data = bank[rd_idx];

endmodule

// File: rtl/matrix_stream_sequencer.sv
// Snapshots NUM_MTRX matrices at frame start and streams them over valid/ready.
// Define MTRX_SEQ_SKIP_EN to honour skip_mask; otherwise it is ignored.
module matrix_stream_sequencer
    import mgpu_mtrx_pkg::*;
#(
    parameter int unsigned NUM_MTRX = 6,
    parameter int unsigned DIM      = DEF_DIM,
    parameter int unsigned ELEM_W   = DEF_ELEM_W,
    parameter int unsigned ST_W     = 4
) (
    input  logic                                CLK,
    input  logic                                rst,
    input  logic                                CPUvalid,
    input  logic                                frame_start,
    input  logic [NUM_MTRX*DIM*DIM*ELEM_W-1:0]  mtrx_in,
    input  logic [NUM_MTRX-1:0]                 skip_mask,
    output logic [DIM*DIM*ELEM_W-1:0]           mtrxOut,
    output logic                                mtrx_valid,
    input  logic                                mtrx_ready,
    output logic [ST_W-1:0]                     matrixState,
    output logic                                frame_done
);

    localparam int unsigned MW    = DIM * DIM * ELEM_W;
    localparam int unsigned IDX_W = (NUM_MTRX > 1) ? $clog2(NUM_MTRX) : 1;

    seq_state_t          state, state_next;
    logic [IDX_W-1:0]    idx, idx_next;
    logic [NUM_MTRX-1:0] skip_in, skip_q;
    logic                done_q, done_next;
    logic                load;
    logic                first_found, next_found;
    logic [IDX_W-1:0]    first_idx, next_idx;
    logic [MW-1:0]       rd_data;

`ifdef MTRX_SEQ_SKIP_EN
    assign skip_in = skip_mask;
`else
    assign skip_in = skip_mask & '0;
`endif

    mtrx_snap_buf #(
        .NUM_MTRX (NUM_MTRX),
        .MTRX_W   (MW),
        .IDX_W    (IDX_W)
    ) u_buf (
        .clk     (CLK),
        .load    (load & ~rst),
        .data_in (mtrx_in),
        .rd_idx  (idx),
        .rd_data (rd_data)
    );

    // First index to present: searched on the live mask, since it is captured on the same edge.
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        for (int unsigned k = 0; k < NUM_MTRX; k++) begin
            if (!first_found && !skip_in[k]) begin
                first_found = 1'b1;
                first_idx   = IDX_W'(k);
            end
        end
    end

    always_comb begin
        next_found = 1'b0;
        next_idx   = '0;
        for (int unsigned k = 0; k < NUM_MTRX; k++) begin
            if (!next_found && (IDX_W'(k) > idx) && !skip_q[k]) begin
                next_found = 1'b1;
                next_idx   = IDX_W'(k);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state  <= ST_IDLE;
            idx    <= '0;
            done_q <= 1'b0;
            skip_q <= '0;
        end else begin
            state  <= state_next;
            idx    <= idx_next;
            done_q <= done_next;
            if (load) begin
                skip_q <= skip_in;
            end
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        done_next  = 1'b0;
        load       = 1'b0;
        if (!CPUvalid) begin
            state_next = ST_IDLE;
            idx_next   = '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (frame_start) begin
                        load = 1'b1;
                        if (first_found) begin
                            state_next = ST_SEND;
                            idx_next   = first_idx;
                        end else begin
                            state_next = ST_DONE;
                            idx_next   = '0;
                            done_next  = 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    if (mtrx_ready) begin
                        if (next_found) begin
                            idx_next = next_idx;
                        end else begin
                            state_next = ST_DONE;
                            idx_next   = '0;
                            done_next  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    idx_next   = '0;
                end
            endcase
        end
    end

    always_comb begin
        mtrx_valid  = 1'b0;
        mtrxOut     = '0;
        matrixState = '0;
        frame_done  = done_q;
        case (state)
            ST_SEND: begin
                mtrx_valid  = 1'b1;
                mtrxOut     = rd_data;
                matrixState = ST_W'(idx) + ST_W'(1);
            end
            ST_DONE: matrixState = ST_W'(NUM_MTRX + 1);
            default: ;
        endcase
    end

endmodule

// File: tb/tb_matrix_stream_sequencer.sv
// Scoreboard bench for matrix_stream_sequencer (defaults: 6 matrices of 4x4x16).
module tb_matrix_stream_sequencer;

    localparam int unsigned N  = 6;
    localparam int unsigned MW = 256;

    logic            CLK = 1'b0;
    logic            rst;
    logic            CPUvalid;
    logic            frame_start;
    logic [N*MW-1:0] mtrx_in;
    logic [N-1:0]    skip_mask;
    logic [MW-1:0]   mtrxOut;
    logic            mtrx_valid;
    logic            mtrx_ready;
    logic [3:0]      matrixState;
    logic            frame_done;

    matrix_stream_sequencer #(
        .NUM_MTRX (6),
        .DIM      (4),
        .ELEM_W   (16),
        .ST_W     (4)
    ) dut (
        .CLK         (CLK),
        .rst         (rst),
        .CPUvalid    (CPUvalid),
        .frame_start (frame_start),
        .mtrx_in     (mtrx_in),
        .skip_mask   (skip_mask),
        .mtrxOut     (mtrxOut),
        .mtrx_valid  (mtrx_valid),
        .mtrx_ready  (mtrx_ready),
        .matrixState (matrixState),
        .frame_done  (frame_done)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int            st;
        logic [MW-1:0] data;
    } exp_t;

    exp_t q[$];
    int   pending_done = 0;
    int   checks = 0;
    int   failures = 0;
    logic mon_en = 1'b0;

    function automatic logic [MW-1:0] mat_of(input int v);
        logic [15:0] e;
        e = 16'(v);
        return {16{e}};
    endfunction

    task automatic check_i(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_v(input string name, input logic [MW-1:0] act, input logic [MW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_mat(input int k);
        exp_t e;
        e.st   = k + 1;
        e.data = mat_of(k + 1);
        q.push_back(e);
    endtask

    task automatic set_pattern();
        for (int k = 0; k < int'(N); k++) begin
            mtrx_in[k*MW +: MW] = mat_of(k + 1);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (pending_done != 0 && n < budget) begin
            tick();
            n++;
        end
        check_i("frame_done_timeout", pending_done, 0);
    endtask

    // Monitor: compares presented data against the scoreboard head; pops on transfer.
    always @(negedge CLK) begin
        if (mon_en) begin
            if (mtrx_valid) begin
                if (q.size() == 0) begin
                    check_i("unexpected_valid", int'(matrixState), 0);
                end else begin
                    check_i("stream_state", int'(matrixState), q[0].st);
                    check_v("stream_data", mtrxOut, q[0].data);
                    if (mtrx_ready) void'(q.pop_front());
                end
            end else begin
                check_v("zero_when_invalid", mtrxOut, '0);
            end
            if (frame_done) begin
                check_i("frame_done_expected", pending_done, 1);
                check_i("frame_done_after_all", q.size(), 0);
                if (pending_done > 0) pending_done--;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int held;
        int guard;
        logic changed;
        logic fs_pulsed;

        rst = 1'b1; CPUvalid = 1'b0; frame_start = 1'b0;
        mtrx_ready = 1'b1; skip_mask = '0; mtrx_in = '0;
        tick(); tick();
        check_i("reset_state", int'(matrixState), 0);
        check_i("reset_valid", int'(mtrx_valid), 0);
        check_i("reset_done", int'(frame_done), 0);
        check_v("reset_data", mtrxOut, '0);

        rst = 1'b0; CPUvalid = 1'b1;
        set_pattern();
        mon_en = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            check_i("idle_state", int'(matrixState), 0);
            check_i("idle_valid", int'(mtrx_valid), 0);
        end

        // Frame 1: ready tied high, cycle-exact timing.
        for (int k = 0; k < int'(N); k++) push_mat(k);
        pending_done = 1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            check_i("f1_valid", int'(mtrx_valid), (c <= 6) ? 1 : 0);
            check_i("f1_state", int'(matrixState), (c <= 7) ? c : 7);
            check_i("f1_frame_done", int'(frame_done), (c == 7) ? 1 : 0);
            tick();
        end
        check_i("f1_pending", pending_done, 0);

        // Frame 2: back-pressure on matrix 2, input changed mid-frame, stray frame_start.
        for (int k = 0; k < int'(N); k++) push_mat(k);
        pending_done = 1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        held = 0; changed = 1'b0; fs_pulsed = 1'b0; guard = 0;
        while (pending_done != 0 && guard < 40) begin
            if (matrixState == 4'd3 && held < 3) begin
                mtrx_ready = 1'b0;
                held++;
            end else begin
                mtrx_ready = 1'b1;
            end
            if (matrixState == 4'd2 && !changed) begin
                mtrx_in = {96{16'h7FFF}};
                changed = 1'b1;
            end
            frame_start = 1'b0;
            if (matrixState == 4'd4 && !fs_pulsed) begin
                frame_start = 1'b1;
                fs_pulsed = 1'b1;
            end
            tick();
            guard++;
        end
        frame_start = 1'b0;
        mtrx_ready = 1'b1;
        check_i("f2_frame_done_timeout", pending_done, 0);
        check_i("f2_backpressure_cycles", held, 3);
        check_i("f2_done_state", int'(matrixState), 7);

        // Frame 3: abort while matrix 3 is presented.
        set_pattern();
        for (int k = 0; k < 4; k++) push_mat(k);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        guard = 0;
        while (matrixState != 4'd4 && guard < 20) begin
            tick();
            guard++;
        end
        check_i("f3_reached_state4", int'(matrixState), 4);
        mtrx_ready = 1'b0;
        CPUvalid = 1'b0;
        @(negedge CLK);
        tick();
        check_i("abort_state", int'(matrixState), 0);
        check_i("abort_valid", int'(mtrx_valid), 0);
        check_i("abort_no_done", int'(frame_done), 0);
        check_i("abort_leftover", q.size(), 1);
        q.delete();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check_i("start_without_cpuvalid", int'(matrixState), 0);
        tick(); tick();
        check_i("abort_idle_held", int'(matrixState), 0);

        // Frame 4: skip mask.
        CPUvalid = 1'b1;
        mtrx_ready = 1'b1;
        skip_mask = 6'b010010;
`ifdef MTRX_SEQ_SKIP_EN
        push_mat(0); push_mat(2); push_mat(3); push_mat(5);
`else
        for (int k = 0; k < int'(N); k++) push_mat(k);
`endif
        pending_done = 1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        wait_done(40);
        tick();

        // Frame 5: all matrices masked.
        skip_mask = '1;
        pending_done = 1;
`ifdef MTRX_SEQ_SKIP_EN
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check_i("allskip_valid", int'(mtrx_valid), 0);
        check_i("allskip_done_pulse", int'(frame_done), 1);
        check_i("allskip_state", int'(matrixState), 7);
        tick();
`else
        for (int k = 0; k < int'(N); k++) push_mat(k);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check_i("mask_ignored_valid", int'(mtrx_valid), 1);
        check_i("mask_ignored_state", int'(matrixState), 1);
`endif
        wait_done(40);
        tick();

        check_i("scoreboard_empty", q.size(), 0);
        check_i("no_pending_done", pending_done, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
